label_hex_writer: RTL and testbench

Writes a live hex value into the character RAM that feeds the on-screen text labels, so counters and registers show up as text without changing the label renderers. It sits upstream of the shared label RAM: it takes an update strobe (typically end-of-frame) and a value snapshot. It then writes one ASCII character per nibble into consecutive RAM addresses, only during video blanking. Its write bus is ORed onto the RAM's shared address/data bus alongside the label readers.

---
 rtl/label_hex_writer_pkg.sv | 14 +
 rtl/label_hex_writer_nibble2digit.sv | 14 +
 rtl/label_hex_writer.sv | 131 +++++++++++++
 tb/tb_label_hex_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/label_hex_writer_pkg.sv
// Shared constants and state encoding for the label hex writer.
package label_hex_writer_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/label_hex_writer_nibble2digit.sv
// Converts one hex nibble into its uppercase ASCII character.
module label_hex_writer_nibble2digit
  import label_hex_writer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) o_ascii = ASCII_ZERO + {4'b0000, i_nibble};
    else                  o_ascii = ASCII_UPPER_A + {4'b0000, i_nibble} - 8'd10;
  end

endmodule

// File: rtl/label_hex_writer.sv
// Writes a hex snapshot of a value into the shared label RAM, one digit per
// blanking cycle, with a depth-1 pending request for updates arriving mid-write.
module label_hex_writer
  import label_hex_writer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NIBBLES    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter bit                    LZ_BLANK   = 1'b0
) (
  input  logic                    px_clk,
  input  logic                    rst,
  input  logic [4*NIBBLES-1:0]    value,
  input  logic                    update,
  input  logic                    blank,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [7:0]              ram_din,
  output logic                    ram_we
);

  localparam int VW = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t                r_state;
  logic [VW-1:0]         r_work;
  logic [VW-1:0]         r_pend;
  logic                  r_pendValid;
  logic [IW-1:0]         r_idx;
  logic                  r_seenNz;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_din;

  logic [3:0] w_nibble;
  logic [7:0] w_digit;
  logic       w_isLast;
  logic       w_lzBlank;
  logic [7:0] w_char;

  // The work register shifts left after each write, so the top nibble is always current.
  assign w_nibble  = r_work[VW-1 -: 4];
  assign w_isLast  = (r_idx == LAST_IDX);
  assign w_lzBlank = LZ_BLANK && !r_seenNz && (w_nibble == 4'd0) && !w_isLast;
  assign w_char    = w_lzBlank ? ASCII_SPACE : w_digit;

  label_hex_writer_nibble2digit u_nibble2digit (
    .i_nibble (w_nibble),
    .o_ascii  (w_digit)
  );

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_idx       <= '0;
      r_seenNz    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
      case (r_state)
        IDLE: begin
          if (update || r_pendValid) begin
            r_work      <= update ? value : r_pend;
            r_pendValid <= 1'b0;
            r_idx       <= '0;
            r_seenNz    <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= WRITE;
          end
        end
        WRITE: begin
          r_busy <= 1'b1;
          if (update) begin
            r_pend      <= value;
            r_pendValid <= 1'b1;
          end
          if (blank) begin
            r_we   <= 1'b1;
            r_addr <= BASE_ADDR + ADDR_WIDTH'(r_idx);
            r_din  <= w_char;
            r_work <= r_work << 4;
            r_idx  <= r_idx + IW'(1);
            if (w_nibble != 4'd0) r_seenNz <= 1'b1;
            if (w_isLast) r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b1;
          if (r_pendValid) begin
            r_work   <= r_pend;
            r_idx    <= '0;
            r_seenNz <= 1'b0;
            r_state  <= WRITE;
          end else begin
            r_state  <= IDLE;
          end
          // A same-cycle update replaces the request just consumed above.
          if (update) begin
            r_pend      <= value;
            r_pendValid <= 1'b1;
          end else begin
            r_pendValid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ram_we   = r_we;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;

endmodule

// File: tb/tb_label_hex_writer.sv
// Directed bench for label_hex_writer: a default instance and a wrapped-base,
// leading-zero-blanking instance share stimulus; written digits go through a scoreboard.
module tb_label_hex_writer;

  logic        px_clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        update;
  logic        blank;

  logic       busyA, doneA, weA;
  logic [7:0] addrA, dinA;
  logic       busyB, doneB, weB;
  logic [7:0] addrB, dinB;

  logic [15:0] qA[$];
  logic [15:0] qB[$];

  int checks = 0;
  int errors = 0;

  always #5 px_clk = ~px_clk;

  label_hex_writer #(.ADDR_WIDTH(8), .NIBBLES(4), .BASE_ADDR(8'h00), .LZ_BLANK(1'b0)) dutA (
    .px_clk(px_clk), .rst(rst), .value(value), .update(update), .blank(blank),
    .busy(busyA), .done(doneA), .ram_addr(addrA), .ram_din(dinA), .ram_we(weA)
  );

  label_hex_writer #(.ADDR_WIDTH(8), .NIBBLES(4), .BASE_ADDR(8'hFE), .LZ_BLANK(1'b1)) dutB (
    .px_clk(px_clk), .rst(rst), .value(value), .update(update), .blank(blank),
    .busy(busyB), .done(doneB), .ram_addr(addrB), .ram_din(dinB), .ram_we(weB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {addr, ascii} pairs for both instances from the value alone.
  function automatic void pushExpected(input logic [15:0] v);
    logic [3:0] nib;
    logic [7:0] ch;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nib = v[15 - 4*i -: 4];
      if (nib != 4'd0) seen = 1'b1;
      ch = (nib < 4'd10) ? (8'h30 + {4'b0, nib}) : (8'h41 + {4'b0, nib} - 8'd10);
      qA.push_back({8'(i), ch});
      qB.push_back({8'hFE + 8'(i), (!seen && i != 3) ? 8'h20 : ch});
    end
  endfunction

  always @(negedge px_clk) begin
    logic [15:0] expA, expB;
    if (weA) begin
      expA = (qA.size() > 0) ? qA.pop_front() : 16'hDEAD;
      checkOutput("A_write", {16'h0, addrA, dinA}, {16'h0, expA});
    end else begin
      checkOutput("A_idle_bus", {16'h0, addrA, dinA}, 32'h0);
    end
    if (weB) begin
      expB = (qB.size() > 0) ? qB.pop_front() : 16'hDEAD;
      checkOutput("B_write", {16'h0, addrB, dinB}, {16'h0, expB});
    end else begin
      checkOutput("B_idle_bus", {16'h0, addrB, dinB}, 32'h0);
    end
  end

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  // Drives a one-cycle update; on return the request has been sampled (cycle c+1).
  task automatic applyStimulus(input logic [15:0] v, input bit expectWrite);
    value  = v;
    update = 1'b1;
    if (expectWrite) pushExpected(v);
    tick();
    update = 1'b0;
  endtask

  // Cycle k counts from the sampling edge; weMask bit k flags an expected write in cycle k.
  task automatic checkWindow(input string tag, input int total, input int offLo, input int offHi,
                             input int doneAt, input logic [15:0] weMask);
    for (int k = 1; k <= total; k++) begin
      blank = !(k >= offLo && k <= offHi);
      @(negedge px_clk);
      checkOutput({tag, "_busyA"}, {31'b0, busyA}, {31'b0, (k < doneAt)});
      checkOutput({tag, "_doneA"}, {31'b0, doneA}, {31'b0, (k == doneAt)});
      checkOutput({tag, "_weA"},   {31'b0, weA},   {31'b0, weMask[k]});
      checkOutput({tag, "_doneB"}, {31'b0, doneB}, {31'b0, (k == doneAt)});
      checkOutput({tag, "_weB"},   {31'b0, weB},   {31'b0, weMask[k]});
      @(posedge px_clk);
      #1;
    end
    blank = 1'b1;
  endtask

  initial begin
    int doneCountA;
    int doneCountB;
    rst    = 1'b1;
    value  = 16'h0;
    update = 1'b0;
    blank  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge px_clk);
    checkOutput("reset_busy", {30'b0, busyA, busyB}, 32'h0);
    checkOutput("reset_done", {30'b0, doneA, doneB}, 32'h0);
    checkOutput("reset_we",   {30'b0, weA, weB},     32'h0);
    tick();

    $display("[TB] basic 12AF with blank held high");
    applyStimulus(16'h12AF, 1'b1);
    checkWindow("basic", 7, 0, -1, 6, 16'h003C);

    $display("[TB] 12AF with blank low for three cycles after second write");
    applyStimulus(16'h12AF, 1'b1);
    checkWindow("paused", 10, 3, 5, 9, 16'h018C);

    $display("[TB] leading zero values");
    applyStimulus(16'h0000, 1'b1);
    checkWindow("zero", 7, 0, -1, 6, 16'h003C);
    applyStimulus(16'h00B0, 1'b1);
    checkWindow("b0", 7, 0, -1, 6, 16'h003C);

    $display("[TB] pending requests, latest wins");
    applyStimulus(16'h1111, 1'b1);
    tick();
    value  = 16'h2222;
    update = 1'b1;
    tick();
    value  = 16'h3333;
    update = 1'b1;
    pushExpected(16'h3333);
    tick();
    update = 1'b0;
    doneCountA = 0;
    doneCountB = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge px_clk);
      if (doneA) doneCountA++;
      if (doneB) doneCountB++;
      tick();
    end
    checkOutput("pending_doneA_count", 32'(doneCountA), 32'd2);
    checkOutput("pending_doneB_count", 32'(doneCountB), 32'd2);
    checkOutput("pending_qA_drained", 32'(qA.size()), 32'd0);
    checkOutput("pending_qB_drained", 32'(qB.size()), 32'd0);

    $display("[TB] reset after second write, update during reset ignored");
    applyStimulus(16'h12AF, 1'b1);
    tick();
    tick();
    rst    = 1'b1;
    value  = 16'h5555;
    update = 1'b1;
    @(negedge px_clk);
    #1;
    qA.delete();
    qB.delete();
    tick();
    rst    = 1'b0;
    update = 1'b0;
    @(negedge px_clk);
    checkOutput("rst_busy", {30'b0, busyA, busyB}, 32'h0);
    checkOutput("rst_we",   {30'b0, weA, weB},     32'h0);
    tick();
    @(negedge px_clk);
    checkOutput("rst_update_ignored", {30'b0, busyA, busyB}, 32'h0);
    tick();
    applyStimulus(16'h12AF, 1'b1);
    checkWindow("restart", 7, 0, -1, 6, 16'h003C);

    repeat (3) tick();
    checkOutput("final_qA_empty", 32'(qA.size()), 32'd0);
    checkOutput("final_qB_empty", 32'(qB.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
